// File: rtl/ch3_wt_seg_reader_if.sv
// Segment-bus reader interface: multiplexed display bus in, captured digits out.
// master drives SEG_DATA/DIGIT_SEL and observes results; slave is the reader.
interface ch3_wt_seg_reader_if;
    logic [7:0]  SEG_DATA;
    logic [5:0]  DIGIT_SEL;
    logic [23:0] BCD_OUT;
    logic [5:0]  DOT_OUT;
    logic [5:0]  VALID;
    logic [5:0]  ERR;
    logic        FRAME_DONE;

    modport master (
        output SEG_DATA, DIGIT_SEL,
        input  BCD_OUT, DOT_OUT, VALID, ERR, FRAME_DONE
    );

    modport slave (
        input  SEG_DATA, DIGIT_SEL,
        output BCD_OUT, DOT_OUT, VALID, ERR, FRAME_DONE
    );
endinterface

// File: rtl/ch3_wt_seg_reader.sv
// Samples a multiplexed 7-seg+DOT bus, debounces each digit strobe and captures
// BCD/DOT/VALID/ERR per digit. Ports: CLK, RESETN, bus (slave modport).
module ch3_wt_seg_reader #(
    parameter int STABLE_CNT = 3
) (
    input  logic CLK,
    input  logic RESETN,
    ch3_wt_seg_reader_if.slave bus
);
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] bcd_q, bcd_d;
    logic [5:0]  dot_q, dot_d;
    logic [5:0]  vld_q, vld_d;
    logic [5:0]  err_q, err_d;
    logic [5:0]  seen_q, seen_d;
    logic        fd_q, fd_d;

    logic        legal;
    logic        same;
    logic        capture;
    logic [3:0]  code;
    logic        bad;
    logic [5:0]  seen_nx;

    assign legal = $onehot(bus.DIGIT_SEL);
    assign same  = (bus.DIGIT_SEL == sel_q) && (bus.SEG_DATA == seg_q);

    always_comb begin
        bad = 1'b0;
        case (bus.SEG_DATA[7:1])
            7'b1111110: code = 4'd0;
            7'b0110000: code = 4'd1;
            7'b1101101: code = 4'd2;
            7'b1111001: code = 4'd3;
            7'b0110011: code = 4'd4;
            7'b1011011: code = 4'd5;
            7'b1011111: code = 4'd6;
            7'b1110000: code = 4'd7;
            7'b1111111: code = 4'd8;
            7'b1111011: code = 4'd9;
            7'b0000000: code = 4'hF;
            default: begin
                code = 4'hE;
                bad  = 1'b1;
            end
        endcase
    end

    // Held sample is cleared on illegal strobes, so a legal sample never
    // matches it afterwards and the count restarts at 1.
    always_comb begin
        sel_d   = sel_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!legal) begin
            sel_d = '0;
            seg_d = '0;
            cnt_d = '0;
        end else if (same) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
            capture = (cnt_q == CNT_MAX - 4'd1);
        end else begin
            sel_d   = bus.DIGIT_SEL;
            seg_d   = bus.SEG_DATA;
            cnt_d   = 4'd1;
            capture = (CNT_MAX == 4'd1);
        end
    end

    always_comb begin
        bcd_d   = bcd_q;
        dot_d   = dot_q;
        vld_d   = vld_q;
        err_d   = err_q;
        seen_nx = seen_q;
        seen_d  = seen_q;
        fd_d    = 1'b0;
        if (capture) begin
            for (int n = 0; n < 6; n++) begin
                if (bus.DIGIT_SEL[n]) begin
                    bcd_d[4*n +: 4] = code;
                    dot_d[n]        = bus.SEG_DATA[0];
                    vld_d[n]        = 1'b1;
                    err_d[n]        = bad;
                end
            end
            seen_nx = seen_q | bus.DIGIT_SEL;
            if (&seen_nx) begin
                seen_d = '0;
                fd_d   = 1'b1;
            end else begin
                seen_d = seen_nx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sel_q  <= '0;
            seg_q  <= '0;
            cnt_q  <= '0;
            bcd_q  <= '0;
            dot_q  <= '0;
            vld_q  <= '0;
            err_q  <= '0;
            seen_q <= '0;
            fd_q   <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            seg_q  <= seg_d;
            cnt_q  <= cnt_d;
            bcd_q  <= bcd_d;
            dot_q  <= dot_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            seen_q <= seen_d;
            fd_q   <= fd_d;
        end
    end

    assign bus.BCD_OUT    = bcd_q;
    assign bus.DOT_OUT    = dot_q;
    assign bus.VALID      = vld_q;
    assign bus.ERR        = err_q;
    assign bus.FRAME_DONE = fd_q;
endmodule

// File: tb/tb_ch3_wt_seg_reader.sv
// Directed bench for ch3_wt_seg_reader (STABLE_CNT=3).
// Drives the bus via the master modport and checks captured digits.
module tb_ch3_wt_seg_reader;
    logic CLK;
    logic RESETN;
    int   n_cmp;
    int   n_bad;

    ch3_wt_seg_reader_if bus ();

    ch3_wt_seg_reader #(.STABLE_CNT(3)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] sel, input logic [7:0] seg);
        bus.DIGIT_SEL = sel;
        bus.SEG_DATA  = seg;
    endtask

    task automatic edges(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    logic [7:0] pat [10];
    int         pulses;
    int         pulse_at;
    int         e;

    task automatic scan();
        pulses   = 0;
        pulse_at = -1;
        e        = 0;
        for (int d = 0; d < 6; d++) begin
            drive(6'(1 << d), pat[d]);
            for (int i = 0; i < 3; i++) begin
                edges(1);
                if (bus.FRAME_DONE) begin
                    pulses++;
                    pulse_at = e;
                end
                e++;
            end
        end
        edges(1);
        if (bus.FRAME_DONE) pulses++;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pat[0] = 8'hFC; pat[1] = 8'h60; pat[2] = 8'hDA; pat[3] = 8'hF2;
        pat[4] = 8'h66; pat[5] = 8'hB6; pat[6] = 8'hBE; pat[7] = 8'hE0;
        pat[8] = 8'hFE; pat[9] = 8'hF6;

        RESETN = 1'b0;
        drive(6'b000001, 8'hF3);
        #3;
        chk("rst_bcd", 32'(bus.BCD_OUT), 32'h0);
        chk("rst_vld", 32'(bus.VALID), 32'h0);
        chk("rst_fd", 32'(bus.FRAME_DONE), 32'h0);
        #9 RESETN = 1'b1;

        // digit 0 = 3 with DOT, 3-edge dwell
        edges(2);
        chk("d0_early_vld", 32'(bus.VALID), 32'h0);
        edges(1);
        chk("d0_bcd", 32'(bus.BCD_OUT[3:0]), 32'h3);
        chk("d0_dot", 32'(bus.DOT_OUT), 32'h01);
        chk("d0_vld", 32'(bus.VALID), 32'h01);
        chk("d0_err", 32'(bus.ERR), 32'h0);
        edges(10);
        chk("d0_hold_bcd", 32'(bus.BCD_OUT), 32'h3);
        chk("d0_hold_vld", 32'(bus.VALID), 32'h01);

        // aborted dwell on digit 2
        drive(6'b000100, 8'hB6);
        edges(2);
        drive(6'b000000, 8'hB6);
        edges(1);
        drive(6'b000100, 8'hB6);
        edges(2);
        chk("abort_vld", 32'(bus.VALID), 32'h01);
        edges(1);
        chk("abort_late_vld", 32'(bus.VALID), 32'h05);
        chk("abort_late_bcd", 32'(bus.BCD_OUT[11:8]), 32'h5);

        // blank then illegal on digit 4
        drive(6'b010000, 8'h00);
        edges(3);
        chk("blank_bcd", 32'(bus.BCD_OUT[19:16]), 32'hF);
        chk("blank_err", 32'(bus.ERR), 32'h0);
        drive(6'b010000, 8'h82);
        edges(3);
        chk("bad_bcd", 32'(bus.BCD_OUT[19:16]), 32'hE);
        chk("bad_err", 32'(bus.ERR), 32'h10);
        chk("bad_vld", 32'(bus.VALID), 32'h15);

        // multi-hot strobe ignored
        drive(6'b110000, 8'hFC);
        edges(5);
        chk("mhot_bcd", 32'(bus.BCD_OUT), 32'h0E0503);
        chk("mhot_vld", 32'(bus.VALID), 32'h15);
        chk("mhot_err", 32'(bus.ERR), 32'h10);
        chk("mhot_dot", 32'(bus.DOT_OUT), 32'h01);

        // reset between edges 2 and 3 of a dwell
        drive(6'b000010, 8'h60);
        edges(2);
        #2 RESETN = 1'b0;
        #1;
        chk("mid_rst_bcd", 32'(bus.BCD_OUT), 32'h0);
        chk("mid_rst_vld", 32'(bus.VALID), 32'h0);
        chk("mid_rst_err", 32'(bus.ERR), 32'h0);
        #8 RESETN = 1'b1;
        edges(2);
        chk("post_rst_early", 32'(bus.VALID), 32'h0);
        edges(1);
        chk("post_rst_vld", 32'(bus.VALID), 32'h02);
        chk("post_rst_bcd", 32'(bus.BCD_OUT[7:4]), 32'h1);

        // two full scans, one pulse each
        scan();
        chk("scan1_pulses", 32'(pulses), 32'd1);
        chk("scan1_pos", 32'(pulse_at), 32'd17);
        chk("scan1_bcd", 32'(bus.BCD_OUT), 32'h543210);
        chk("scan1_vld", 32'(bus.VALID), 32'h3F);
        chk("scan1_err", 32'(bus.ERR), 32'h0);
        scan();
        chk("scan2_pulses", 32'(pulses), 32'd1);
        chk("scan2_pos", 32'(pulse_at), 32'd17);

        // remaining decodes on digit 3
        for (int v = 6; v < 10; v++) begin
            drive(6'b001000, pat[v]);
            edges(3);
            chk($sformatf("dec%0d", v), 32'(bus.BCD_OUT[15:12]), 32'(v));
        end
        chk("dec_fd", 32'(bus.FRAME_DONE), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
